mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port unified RAM between the instruction-fetch port (IF) and the load/store port (LS).
- Arbitration is single-cycle. LS has priority, and a bounded starvation counter guarantees forward progress for IF.
- Read data is captured and returned one cycle after grant with a valid strobe. Writes are acknowledged the same way.
- Sits between the core pipeline and the RAM, and drives the RAM's write enable, address and write data.

Parameters:
- ADDR_WIDTH, 32, byte address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 32, word width (matches `DATA_WIDTH).
- MAX_LS_STREAK, 4, max consecutive LS grants while IF is waiting; range 1..15.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_req_i  in  1  IF read request; held with address until granted.
- if_addr_i  in  ADDR_WIDTH  IF byte address.
- if_gnt_o  out  1  IF request accepted this cycle.
- if_rvalid_o  out  1  IF read data valid, one cycle after grant.
- if_rdata_o  out  DATA_WIDTH  IF read data.
- ls_req_i  in  1  LS request; held with operands until granted.
- ls_we_i  in  1  LS write (1) / read (0).
- ls_addr_i  in  ADDR_WIDTH  LS byte address.
- ls_wdata_i  in  DATA_WIDTH  LS write data.
- ls_gnt_o  out  1  LS request accepted this cycle.
- ls_rvalid_o  out  1  LS response (read data or write ack), one cycle after grant.
- ls_rdata_o  out  DATA_WIDTH  LS read data; zero on write ack.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_data_o  out  DATA_WIDTH  RAM write data.
- ram_data_i  in  DATA_WIDTH  RAM read data, combinational from ram_addr_o.

Behaviour:
- Arbitration (combinational, same cycle as request):
  - Only IF requesting -> IF granted.
  - Only LS requesting -> LS granted.
  - Both requesting -> LS granted unless streak == MAX_LS_STREAK, in which case IF is granted.
- if_gnt_o and ls_gnt_o are never high together.
- Both grants are forced to 0 while rst_i=1.
- RAM mux:
  - On IF grant: ram_addr_o = if_addr_i, ram_we_o = 0.
  - On LS grant: ram_addr_o = ls_addr_i, ram_we_o = ls_we_i, ram_data_o = ls_wdata_i.
  - With no grant, or during reset: ram_addr_o = 0, ram_we_o = 0, ram_data_o = 0.
- Handshake:
  - A request is accepted on the rising edge where req && gnt.
  - The requester may change its address or operation only after acceptance.
  - A requester may issue back-to-back requests; throughput is one accepted request per cycle total.
- Response (registered):
  - At the accepting edge, the granted port's rvalid register is set and rdata is captured from ram_data_i (reads) or set to 0 (LS writes).
  - rvalid is high for exactly one cycle unless another grant occurs that cycle.
  - The non-granted port's rvalid is cleared at that edge.
- Streak counter (4 bits):
  - Increments on an LS grant while if_req_i=1, saturating at MAX_LS_STREAK.
  - Clears on any IF grant, or on any cycle with if_req_i=0.
- Write-then-read to the same address: a read granted the cycle after a write returns the new data, because the RAM write commits at the accepting edge.
- Reset values (all synchronous):
  - if_rvalid_o = 0, ls_rvalid_o = 0.
  - if_rdata_o = 0, ls_rdata_o = 0.
  - streak = 0.
- Reset mid-transaction:
  - A response pending at the reset edge is dropped (rvalid = 0 after the edge).
  - No write is issued while rst_i=1.
  - Requesters must re-request after reset.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with both requests high -> both gnt=0, ram_we_o=0, both rvalid=0, both rdata=0.
- IF only: preload RAM[0x40]=0xDEADBEEF; if_req_i=1, if_addr_i=0x40 -> if_gnt_o=1 same cycle; next cycle if_rvalid_o=1 with if_rdata_o=0xDEADBEEF, ls_rvalid_o=0.
- LS write then read: write 0x12345678 to 0x80, then read 0x80 -> first response ls_rvalid_o=1 with rdata=0; second response ls_rdata_o=0x12345678.
- Contention, MAX_LS_STREAK=4: both request continuously -> grant pattern LS,LS,LS,LS,IF repeating; IF granted on cycles 5, 10, 15.
- Streak clear: LS granted 3 times with IF requesting, then IF drops for 1 cycle, then re-requests -> 4 more LS grants occur before IF wins.
- Reset mid-op: assert rst_i on the cycle after an LS read grant -> ls_rvalid_o=0 after the edge, ram_we_o=0, streak=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Unified-RAM arbiter between instruction fetch and load/store.
// LS wins contention; a bounded streak counter keeps IF moving.
module mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
);

  localparam logic [3:0] MaxStreak = 4'(MAX_LS_STREAK);

  logic                  if_gnt;
  logic                  ls_gnt;
  logic                  if_due;

  logic [3:0]            streak_q;
  logic [3:0]            streak_d;
  logic                  if_rvalid_q;
  logic                  if_rvalid_d;
  logic                  ls_rvalid_q;
  logic                  ls_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q;
  logic [DATA_WIDTH-1:0] ls_rdata_d;

  assign if_due = (streak_q == MaxStreak);

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst_i) begin
      if (if_req_i && (!ls_req_i || if_due)) begin
        if_gnt = 1'b1;
      end else if (ls_req_i) begin
        ls_gnt = 1'b1;
      end
    end
  end

  assign if_gnt_o = if_gnt;
  assign ls_gnt_o = ls_gnt;

  always_comb begin
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    unique case (1'b1)
      if_gnt: begin
        ram_addr_o = if_addr_i;
      end
      ls_gnt: begin
        ram_we_o   = ls_we_i;
        ram_addr_o = ls_addr_i;
        ram_data_o = ls_wdata_i;
      end
      default: ;
    endcase
  end

  // Streak only counts LS wins that actually made IF wait.
  always_comb begin
    streak_d = streak_q;
    if (if_gnt || !if_req_i) begin
      streak_d = '0;
    end else if (ls_gnt && !if_due) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_comb begin
    if_rvalid_d = if_gnt;
    ls_rvalid_d = ls_gnt;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if (if_gnt) begin
      if_rdata_d = ram_data_i;
    end
    if (ls_gnt) begin
      ls_rdata_d = ls_we_i ? '0 : ram_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      streak_q    <= streak_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule
